// File: rtl/display_scan_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Multiplexed 7-segment display scanner. The scan works from
//               shadow copies of the display inputs that are only refreshed
//               while idle or at a frame boundary, so a frame is never torn.
//               Each enabled digit is preceded by BLANK_CYCLES all-off cycles
//               and then lit for max(on_time,1) cycles.
// Ports       : clock      - rising-edge clock
//               reset      - synchronous active-high reset
//               value      - hex nibbles, digit k = value[4k+3:4k]
//               en_mask    - digit k is scanned when bit k is set
//               dp_mask    - decimal point k lit when bit k is set
//               on_time    - digit on-time in cycles (0 behaves as 1)
//               an         - active-low anode enables (registered)
//               seg        - active-low segments {g,f,e,d,c,b,a} (registered)
//               dp         - active-low decimal point (registered)
//               frame_done - one-cycle pulse when the last enabled digit ends
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     en_mask,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [15:0]             on_time,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;

    // Blank counter counts 0 .. BLANK_CYCLES-1, so it never reaches 255.
    localparam logic [7:0] c_blank_last = 8'(BLANK_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]              r_state;
    logic [c_idx_w-1:0]      r_idx;
    logic [7:0]              r_blank_cnt;
    logic [15:0]             r_on_cnt;
    logic [4*N_DIGITS-1:0]   r_value;
    logic [N_DIGITS-1:0]     r_en_mask;
    logic [N_DIGITS-1:0]     r_dp_mask;
    logic [15:0]             r_on_time;

    // ------------------------------------------------------------------------
    // Combinational next-state / next-output values
    // ------------------------------------------------------------------------
    logic [1:0]              w_state_nxt;
    logic [c_idx_w-1:0]      w_idx_nxt;
    logic [7:0]              w_blank_cnt_nxt;
    logic [15:0]             w_on_cnt_nxt;
    logic                    w_load;
    logic                    w_frame_end;
    logic [15:0]             w_on_last;
    logic                    w_has_higher;
    logic [c_idx_w-1:0]      w_next_idx;
    logic [c_idx_w-1:0]      w_lowest_in;
    logic [N_DIGITS-1:0]     w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;
    logic [3:0]              w_nibble;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Lowest set bit of the incoming en_mask; used when a new frame is loaded.
    always_comb begin
        w_lowest_in = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                w_lowest_in = c_idx_w'(k);
            end
        end
    end

    // Next enabled digit above the current one in the shadow mask.
    always_comb begin
        w_has_higher = 1'b0;
        w_next_idx   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (r_en_mask[k] && (k > int'(r_idx))) begin
                w_has_higher = 1'b1;
                w_next_idx   = c_idx_w'(k);
            end
        end
    end

    // An on_time of 0 is stretched to a single cycle.
    assign w_on_last = (r_on_time == 16'd0) ? 16'd0 : (r_on_time - 16'd1);

    // ------------------------------------------------------------------------
    // State register (also holds counters, shadows and registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_blank_cnt <= '0;
            r_on_cnt    <= '0;
            r_value     <= '0;
            r_en_mask   <= '0;
            r_dp_mask   <= '0;
            r_on_time   <= '0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
            r_on_cnt    <= w_on_cnt_nxt;
            if (w_load) begin
                r_value   <= value;
                r_en_mask <= en_mask;
                r_dp_mask <= dp_mask;
                r_on_time <= on_time;
            end
            an          <= w_an_nxt;
            seg         <= w_seg_nxt;
            dp          <= w_dp_nxt;
            frame_done  <= w_frame_end;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_blank_cnt_nxt = r_blank_cnt;
        w_on_cnt_nxt    = r_on_cnt;
        w_load          = 1'b0;
        w_frame_end     = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Shadows track the inputs every idle cycle; the decision uses
                // the same values that are being captured.
                w_load          = 1'b1;
                w_blank_cnt_nxt = '0;
                w_on_cnt_nxt    = '0;
                if (|en_mask) begin
                    w_state_nxt = c_st_blank;
                    w_idx_nxt   = w_lowest_in;
                end
            end
            c_st_blank: begin
                if (r_blank_cnt == c_blank_last) begin
                    w_state_nxt     = c_st_show;
                    w_blank_cnt_nxt = '0;
                    w_on_cnt_nxt    = '0;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt + 8'd1;
                end
            end
            c_st_show: begin
                if (r_on_cnt == w_on_last) begin
                    w_on_cnt_nxt = '0;
                    if (w_has_higher) begin
                        w_state_nxt = c_st_blank;
                        w_idx_nxt   = w_next_idx;
                    end else begin
                        // Frame boundary: the only place mid-scan inputs
                        // are allowed to take effect.
                        w_frame_end = 1'b1;
                        w_load      = 1'b1;
                        if (|en_mask) begin
                            w_state_nxt = c_st_blank;
                            w_idx_nxt   = w_lowest_in;
                        end else begin
                            w_state_nxt = c_st_idle;
                            w_idx_nxt   = '0;
                        end
                    end
                end else begin
                    w_on_cnt_nxt = r_on_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: outputs are computed for the state being entered and then
    // registered, so they line up with the state register. Shadows never
    // change on a BLANK->SHOW or SHOW->SHOW step, so the current shadows are
    // the right source whenever the next state is SHOW.
    // ------------------------------------------------------------------------
    assign w_nibble = r_value[4*int'(w_idx_nxt) +: 4];

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (w_state_nxt == c_st_show) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt           = f_decode(w_nibble);
            w_dp_nxt            = ~r_dp_mask[w_idx_nxt];
        end
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of multiplexed 7-segment digits. The value port carries 4*N_DIGITS bits.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: all-anodes-off cycles inserted before each digit (anti-ghosting); legal range 1..255.
REQ-003 SHALL have port clock, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port value, input, 4*N_DIGITS: hex nibbles; digit k = value[4k+3:4k].
REQ-006 SHALL have port en_mask, input, N_DIGITS: digit k scanned when bit k = 1.
REQ-007 SHALL have port dp_mask, input, N_DIGITS: decimal point k lit when bit k = 1.
REQ-008 SHALL have port on_time, input, 16: digit on-time in cycles; 0 is treated as 1.
REQ-009 SHALL have port an, output, N_DIGITS: active-low anode enables.
REQ-010 SHALL have port seg, output, 7: active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1: active-low decimal point.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at end of last enabled digit of a frame.

Function
REQ-013 SHALL register all outputs; no combinational input-to-output path.
REQ-014 SHALL hold shadow copies of value, en_mask, dp_mask and on_time; the scan SHALL use only the shadows.
REQ-015 SHALL implement FSM states IDLE, BLANK and SHOW.
REQ-016 IDLE: SHALL drive an all-1, seg 7'h7F, dp 1; SHALL load shadows every cycle; SHALL go to BLANK when the loaded en_mask is nonzero, with idx = lowest set bit.
REQ-017 BLANK: SHALL drive an all-1, seg 7'h7F, dp 1 for exactly BLANK_CYCLES cycles, then go to SHOW.
REQ-018 SHOW: SHALL drive an[idx]=0 (others 1), seg=decode(shadow nibble idx), dp=~shadow dp_mask[idx] for exactly max(shadow on_time,1) cycles.
REQ-019 At end of SHOW with a higher enabled digit: SHALL set idx = next higher set bit of shadow en_mask (disabled digits skipped) and go to BLANK.
REQ-020 At end of SHOW with no higher enabled digit: SHALL pulse frame_done for 1 cycle and reload all shadows from the inputs.
REQ-021 After that reload: SHALL go to IDLE if the new en_mask = 0; otherwise SHALL go to BLANK with idx = lowest set bit of the new mask.
REQ-022 Input changes mid-frame SHALL have no effect until the frame boundary; a frame is never torn.
REQ-023 Decode: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, 7-bit).
REQ-024 SHALL use a 16-bit on-time counter and an 8-bit blank counter; neither SHALL wrap.
REQ-025 Per-frame period SHALL be (number of enabled digits)*(BLANK_CYCLES+max(on_time,1)) cycles.
REQ-026 A single enabled digit SHALL repeat BLANK/SHOW on that digit, pulsing frame_done once per repeat.

Reset
REQ-027 While reset=1 at a clock edge: SHALL set state=IDLE, idx=0, counters=0, shadows=0, an all-1, seg 7'h7F, dp=1, frame_done=0.
REQ-028 Reset asserted mid-SHOW or mid-BLANK SHALL blank the outputs on the next edge; no frame_done pulse SHALL be emitted.
REQ-029 First cycle after reset deasserts: SHALL behave as IDLE.

Verification
REQ-030 value=32'h76543210, en_mask=FF, dp_mask=00, on_time=3 -> an steps FE,FD,...,7F; seg 40,79,24,30,19,12,02,78; each digit held 3 cycles after 2 blank cycles; frame_done every 40 cycles.
REQ-031 en_mask=8'b0010_0101, on_time=0 -> only digits 0,2,5 lit, each 1 cycle; frame_done every 9 cycles.
REQ-032 Change value mid-frame from 32'h0 to 32'hFFFFFFFF -> remaining digits of current frame still show 40; next frame shows 0E on all digits.
REQ-033 en_mask FF->00 mid-frame -> current frame completes, frame_done pulses, then an stays FF.
REQ-034 dp_mask=8'h80, value=32'h8xxxxxxx, en_mask=80 -> an=7F, seg=00, dp=0 during SHOW; dp=1 during BLANK.
REQ-035 Assert reset during SHOW of digit 3 -> next edge an=FF, seg=7F; no frame_done pulse; scan restarts from the lowest enabled digit after release.
